logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, two-stage pipelined bitwise logic unit with valid/ready flow control.
//  Successor to the combinational 32-bit logic unit: same 3-bit opcode map, any WIDTH.
//  Adds registered operands and result, backpressure, and per-result flags.
//  Sits between the decode/issue stage and writeback, beside the arithmetic unit.
// PARAMETERS
//  WIDTH     32   operand/result width in bits, >= 2
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_valid    in   1      upstream presents op/op1/op2
//  in_ready    out  1      unit accepts this cycle
//  in_op       in   3      opcode (see BEHAVIOUR)
//  in_op1      in   WIDTH  operand 1
//  in_op2      in   WIDTH  operand 2 (ignored for unary ops)
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_data    out  WIDTH  result
//  out_parity  out  1      XOR-reduction of out_data
//  out_zero    out  1      out_data == 0 (see CONFIGURATION)
// BEHAVIOUR
//  Opcodes: 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT op1, 101 NOR,
//   110 two's complement of op1 (~op1 + 1, truncated to WIDTH, carry dropped), 111 XNOR.
//  Stage S1: registers op/op1/op2 plus s1_valid on accept (in_valid && in_ready).
//  Stage S2: computes result from S1 registers; registers out_data, flags, out_valid.
//  Latency: accepted at edge N -> out_valid high after edge N+1 (2nd edge incl. capture).
//  Throughput: one op/cycle while out_ready held high.
//  Ready chain (combinational, no bubbles):
//   s2_adv   = !out_valid || out_ready
//   s1_adv   = !s1_valid || s2_adv
//   in_ready = s1_adv
//  S2 loads when s2_adv; out_valid <= s1_valid on that edge.
//  S1 loads when s1_adv; s1_valid <= in_valid on that edge.
//  Holding: out_valid && !out_ready -> out_data/flags/out_valid stable; S1 holds if full.
//  Full stall: both stages valid, out_ready low -> in_ready low; no data lost/duplicated.
//  Simultaneous accept and drain with both full -> both stages shift; in_ready stays high.
//  in_valid may drop without accept; protocol does not require upstream to hold.
//  2's complement of 0 -> 0; of 1000..0 -> 1000..0 (no overflow flag).
//  Reset (rst_n low at edge): s1_valid, out_valid = 0; out_data = 0; out_parity = 0;
//   out_zero = 0; in_ready = 1 from the first cycle after reset.
//  Reset mid-operation: in-flight ops discarded, no output produced for them.
//  No simulation $display in RTL.
// CONFIGURATION
//  LOGIC_UNIT_ZERO_FLAG_EN defined: out_zero registered with out_data, = (result == 0).
//  Not defined: out_zero tied 0; no compare logic synthesised; port remains.
//  out_parity always present.
// TESTING
//  1 WIDTH=32, op=000, op1=F0F0_F0F0, op2=FF00_FF00, out_ready=1 -> 2 cycles later
//    out_data=F000_F000, parity=0.
//  2 All 8 ops back-to-back with op1=0000_00FF, op2=0000_0F0F -> results in order, 1/cycle:
//    0000_000F, 0000_0FF0, FFFF_FFF0, 0000_0FFF, FFFF_FF00, FFFF_F000, FFFF_FF01, FFFF_F00F.
//  3 Stall: 3 ops issued, out_ready low 5 cycles -> in_ready low after 2 accepts,
//    out_data stable; out_ready high -> all 3 results delivered once, in order.
//  4 WIDTH=8, op=110: op1=00 -> 00; op1=80 -> 80; op1=01 -> FF (parity=0).
//  5 ZERO_FLAG_EN: op=000, op1=AAAA_AAAA, op2=5555_5555 -> out_zero=1; without the macro -> 0.
//  6 rst_n low while 2 ops in flight -> next cycle out_valid=0, out_data=0, in_ready=1,
//    no stale output after release.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control.
// Optional feature macro: LOGIC_UNIT_ZERO_FLAG_EN (registered result==0 flag on out_zero).
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             s1_valid_reg;
    logic [2:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_op1_reg;
    logic [WIDTH-1:0] s1_op2_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_parity_reg;
    logic [WIDTH-1:0] result_next;
    logic             s1_adv;
    logic             s2_adv;

    // Ready chain is purely combinational so a full pipe can shift in the same cycle it drains.
    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        result_next = '0;
        case (s1_op_reg)
            3'b000:  result_next = s1_op1_reg & s1_op2_reg;
            3'b001:  result_next = s1_op1_reg ^ s1_op2_reg;
            3'b010:  result_next = ~(s1_op1_reg & s1_op2_reg);
            3'b011:  result_next = s1_op1_reg | s1_op2_reg;
            3'b100:  result_next = ~s1_op1_reg;
            3'b101:  result_next = ~(s1_op1_reg | s1_op2_reg);
            3'b110:  result_next = (~s1_op1_reg) + ONE;
            default: result_next = ~(s1_op1_reg ^ s1_op2_reg);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 3'b000;
            s1_op1_reg   <= '0;
            s1_op2_reg   <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_op_reg  <= in_op;
                s1_op1_reg <= in_op1;
                s1_op2_reg <= in_op2;
            end
        end
    end

    // Result registers only change on a real result, so they hold while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_parity_reg <= 1'b0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg   <= result_next;
                out_parity_reg <= ^result_next;
            end
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic out_zero_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_zero_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            out_zero_reg <= (result_next == '0);
        end
    end

    assign out_zero = out_zero_reg;
`else
    assign out_zero = 1'b0;
`endif

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_parity = out_parity_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: a 32-bit and an 8-bit instance.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_parity, out_zero;
    logic [2:0]  in_op;
    logic [31:0] in_op1, in_op2, out_data;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_parity8, out_zero8;
    logic [2:0]  in_op8;
    logic [7:0]  in_op1_8, in_op2_8, out_data8;

    int checks = 0;
    int errors = 0;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    localparam logic ZF_ON = 1'b1;
`else
    localparam logic ZF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_op1(in_op1), .in_op2(in_op2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_zero(out_zero)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
        .in_op1(in_op1_8), .in_op2(in_op2_8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_parity(out_parity8), .out_zero(out_zero8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_op1 = '0; in_op2 = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_op8 = 3'd0; in_op1_8 = '0; in_op2_8 = '0; out_ready8 = 1'b1;
        step(); step();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (out_parity !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", out_parity, out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        $display("reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
    endtask

    task automatic test_and();
        in_valid = 1'b1; in_op = 3'b000; in_op1 = 32'hF0F0_F0F0; in_op2 = 32'hFF00_FF00;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_latency_early got=%b want=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid got=%b want=1", out_valid); end
        checks++; if (out_data !== 32'hF000_F000) begin errors++; $display("FAIL and_data got=%h want=f000f000", out_data); end
        checks++; if (out_parity !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL and_flags got=%b%b want=00", out_parity, out_zero); end
        $display("and: out_data=%h parity=%b", out_data, out_parity);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_tab [8];
        exp_tab[0] = 32'h0000_000F; exp_tab[1] = 32'h0000_0FF0; exp_tab[2] = 32'hFFFF_FFF0; exp_tab[3] = 32'h0000_0FFF;
        exp_tab[4] = 32'hFFFF_FF00; exp_tab[5] = 32'hFFFF_F000; exp_tab[6] = 32'hFFFF_FF01; exp_tab[7] = 32'hFFFF_F00F;
        in_op1 = 32'h0000_00FF; in_op2 = 32'h0000_0F0F;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; in_op = 3'(k);
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready op=%0d got=%b want=1", k, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_tab[k-1]) begin
                    errors++; $display("FAIL b2b_result op=%0d got=%b/%h want=1/%h", k-1, out_valid, out_data, exp_tab[k-1]);
                end
                $display("b2b: op=%0d out_data=%h", k-1, out_data);
            end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_op1 = 32'h1234_5678; in_op2 = 32'h0F0F_0F0F;
        in_valid = 1'b1; in_op = 3'b000;
        step();
        in_op = 3'b011;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_second_accept got=%b want=1", in_ready); end
        step();
        in_op = 3'b001;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0204_0608) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=rdy%b v%b %h want=rdy0 v1 02040608", c, in_ready, out_valid, out_data);
            end
            $display("stall: cyc=%0d in_ready=%b out_data=%h", c, in_ready, out_data);
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1F3F_5F7F) begin errors++; $display("FAIL stall_second got=%b/%h want=1/1f3f5f7f", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1D3B_5977) begin errors++; $display("FAIL stall_third got=%b/%h want=1/1d3b5977", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b want=0", out_valid); end
        $display("stall: drained out_valid=%b", out_valid);
    endtask

    task automatic test_negate8();
        logic [7:0] ops [3];
        logic [7:0] res [3];
        logic       par [3];
        ops[0] = 8'h00; ops[1] = 8'h80; ops[2] = 8'h01;
        res[0] = 8'h00; res[1] = 8'h80; res[2] = 8'hFF;
        par[0] = 1'b0;  par[1] = 1'b1;  par[2] = 1'b0;
        in_op8 = 3'b110; in_op2_8 = 8'h5A;
        for (int k = 0; k <= 3; k++) begin
            in_valid8 = (k < 3);
            if (k < 3) in_op1_8 = ops[k];
            step();
            if (k >= 1) begin
                checks++;
                if (out_valid8 !== 1'b1 || out_data8 !== res[k-1] || out_parity8 !== par[k-1]) begin
                    errors++; $display("FAIL neg8 op1=%h got=%b/%h/p%b want=1/%h/p%b", ops[k-1], out_valid8, out_data8, out_parity8, res[k-1], par[k-1]);
                end
                $display("neg8: op1=%h out_data=%h parity=%b", ops[k-1], out_data8, out_parity8);
            end
            if (k == 1) begin
                checks++; if (out_zero8 !== ZF_ON) begin errors++; $display("FAIL neg8_zero got=%b want=%b", out_zero8, ZF_ON); end
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_zero_flag();
        in_valid = 1'b1; in_op = 3'b000; in_op1 = 32'hAAAA_AAAA; in_op2 = 32'h5555_5555;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin errors++; $display("FAIL zero_data got=%b/%h want=1/0", out_valid, out_data); end
        checks++; if (out_zero !== ZF_ON) begin errors++; $display("FAIL zero_flag got=%b want=%b", out_zero, ZF_ON); end
        $display("zero: out_data=%h out_zero=%b", out_data, out_zero);
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b011; in_op1 = 32'h0000_1111; in_op2 = 32'h2222_0000;
        step();
        in_op = 3'b100;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got=v%b rdy%b want=v1 rdy0", out_valid, in_ready); end
        rst_n = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_parity !== 1'b0 || out_zero !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got=v%b %h rdy%b p%b z%b want=v0 0 rdy1 p0 z0", out_valid, out_data, in_ready, out_parity, out_zero);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rstmid_stale cyc=%0d got=%b/%h want=0/0", c, out_valid, out_data); end
        end
        $display("reset_mid: out_valid=%b out_data=%h", out_valid, out_data);
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_stall();
        test_negate8();
        test_zero_flag();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
